romload_writer: RTL and testbench
=================================

Name: romload_writer

Overview:
- Downstream consumer of the floppy/OSD controller's ROM/EDD loader strobes: rom_hold, rom_addr, rom_page, rom_data, rom_wr.
- Buffers each byte write in a small FIFO and arbitrates for the shared Vector-06C memory bus.
- Writes each byte into main RAM (page 0) or kvaz RAM-disk pages (page 1..63).
- Holds the host 8080 CPU while loading is requested or any write is still outstanding.

Parameters:
- FIFO_DEPTH, 4, entries in the write FIFO; power of two, 2..16.
- WR_CYCLES, 2, clk cycles o_mem_we stays high per granted write; 1..7.
- PTR_W, 2, FIFO pointer width; equals log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- i_rom_hold  in  1  loader hold request (osd_command bit 3)
- i_rom_page  in  6  target page; 0 = main RAM, 1..63 = kvaz page
- i_rom_addr  in  16  byte address within page
- i_rom_data  in  8  byte to write
- i_rom_wr  in  1  one-cycle write strobe; page/addr/data valid in the same cycle
- i_mem_gnt  in  1  arbiter grant; may arrive any number of cycles after o_mem_req
- o_mem_req  out  1  memory bus request
- o_mem_addr  out  22  {page, addr}
- o_mem_data  out  8  write data
- o_mem_we  out  1  write enable
- o_cpu_hold  out  1  host CPU hold
- o_busy  out  1  FIFO non-empty or write in flight
- o_overflow  out  1  sticky: a strobe was dropped because the FIFO was full

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE. Reset is synchronous and aborts any write in progress; the current entry is discarded and o_mem_we drops on the next edge.
- Capture:
  - On i_rom_wr with FIFO not full, push {page, addr, data}; the entry is visible to the FSM the next cycle.
  - On i_rom_wr with FIFO full, drop the strobe and set o_overflow.
- o_overflow clears only on reset or on a rising edge of i_rom_hold (new load session).
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged, and a full FIFO accepts the push.
- FSM states:
  - IDLE: if FIFO not empty, go to REQ and assert o_mem_req.
  - REQ: hold o_mem_req until i_mem_gnt is sampled high. Then pop the FIFO head into output registers o_mem_addr and o_mem_data, deassert o_mem_req, and go to WRITE.
  - WRITE: o_mem_we high for exactly WR_CYCLES cycles via a down-counter; address and data stay stable throughout. Then go to DONE.
  - DONE: o_mem_we low for 1 cycle of bus turnaround. Go to REQ if FIFO not empty, else IDLE.
- Latency: with i_mem_gnt tied high, an i_rom_wr into an empty FIFO gives the first o_mem_we cycle 3 clocks later (push, IDLE→REQ, REQ→WRITE). Sustained throughput is one byte per WR_CYCLES+2 clocks.
- Grant rules:
  - i_mem_gnt outside REQ is ignored.
  - o_mem_req never drops before a grant.
- o_mem_addr and o_mem_data hold their last values when idle; only o_mem_we qualifies them.
- o_busy = FIFO not empty OR state not IDLE.
- o_cpu_hold = i_rom_hold OR o_busy, registered for one cycle. The CPU is therefore released only after the final write's DONE cycle, even if i_rom_hold falls earlier.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses a PTR_W+1-bit counter to distinguish full from empty.

Optional Feature:
- Macro: ROMLOAD_CKSUM_EN.
- When defined:
  - Adds output o_cksum [15:0], a 16-bit wrapping sum of every byte actually written (on the first o_mem_we cycle of each write).
  - o_cksum clears on reset and on a rising edge of i_rom_hold.
  - Firmware compares it with the file checksum.
- When undefined: the port and its adder are absent; all other behaviour is identical.

Decomposition:
- Shared package romload_pkg holds:
  - FSM state encodings: IDLE=0, REQ=1, WRITE=2, DONE=3.
  - Entry field offsets: data [7:0], addr [23:8], page [29:24].
  - Constant ENTRY_W = 30.
- One sub-module: romload_fifo, a synchronous single-clock FIFO parameterised by depth and width, with push/pop/full/empty and count outputs. The FSM, arbitration and hold logic stay in the top.

Test Plan:
- Single write, gnt tied 1: page=0, addr=16'h0100, data=8'hC3 strobe → o_mem_we high 2 cycles starting 3 clocks later with o_mem_addr=22'h000100 and o_mem_data=C3; o_busy falls after DONE.
- Kvaz page: page=6'h05, addr=16'hFFFF, data=8'h55 → o_mem_addr=22'h05FFFF, o_mem_data=55.
- Grant delay: gnt low for 10 cycles → o_mem_req stays high and no o_mem_we until the cycle after gnt; address/data are those of the head entry.
- Overflow: gnt held low, 5 strobes with data 01..05 → FIFO full at 4, o_overflow=1. After gnt, writes 01..04 appear in order and 05 never appears. Re-raising i_rom_hold clears o_overflow.
- Hold extension: i_rom_hold drops while 3 entries are pending → o_cpu_hold stays 1 until one cycle after the last DONE.
- Reset mid-WRITE: reset_n low during the first o_mem_we cycle → the next cycle o_mem_we=0, FIFO empty, all outputs 0. With ROMLOAD_CKSUM_EN, bytes 0xFF,0x02 give o_cksum=16'h0101.

Source files
------------

// File: rtl/romload_pkg.sv
// Shared types and entry layout for the ROM/EDD loader write path.
// Entry layout: {page, addr, data}; the ROMLOAD_CKSUM_EN build option lives in romload_writer.
package romload_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ENTRY_W  = 30;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 8;
  localparam int ADDR_LSB = 8;
  localparam int ADDR_W   = 16;
  localparam int PAGE_LSB = 24;
  localparam int PAGE_W   = 6;
  localparam int CNT_W    = 3;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [PAGE_W-1:0] page,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    return {page, addr, data};
  endfunction

endpackage

// File: rtl/romload_fifo.sv
// Single-clock FIFO with count; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module romload_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 30,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/romload_writer.sv
// Buffers loader byte strobes and writes them to main RAM / kvaz pages over the shared bus.
// Define ROMLOAD_CKSUM_EN to add the o_cksum running byte sum output.
module romload_writer
  import romload_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYCLES  = 2,
  parameter int PTR_W      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_rom_hold,
  input  logic [5:0]  i_rom_page,
  input  logic [15:0] i_rom_addr,
  input  logic [7:0]  i_rom_data,
  input  logic        i_rom_wr,
  input  logic        i_mem_gnt,
  output logic        o_mem_req,
  output logic [21:0] o_mem_addr,
  output logic [7:0]  o_mem_data,
  output logic        o_mem_we,
  output logic        o_cpu_hold,
  output logic        o_busy,
`ifdef ROMLOAD_CKSUM_EN
  output logic        o_overflow,
  output logic [15:0] o_cksum
`else
  output logic        o_overflow
`endif
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   wr_cnt;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PTR_W:0]     fifo_count;
  logic               pop;
  logic               drop;
  logic               hold_q;
  logic               hold_rise;

  assign pop       = (state == REQ) && i_mem_gnt && !fifo_empty;
  assign drop      = i_rom_wr && fifo_full && !pop;
  assign hold_rise = i_rom_hold && !hold_q;

  romload_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (i_rom_wr),
    .wdata   (pack_entry(i_rom_page, i_rom_addr, i_rom_data)),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = REQ;
      REQ:     if (i_mem_gnt)   state_next = WRITE;
      WRITE:   if (wr_cnt == '0) state_next = DONE;
      DONE:    state_next = fifo_empty ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  assign o_mem_req = (state == REQ);
  assign o_mem_we  = (state == WRITE);
  assign o_busy    = (fifo_count != '0) || (state != IDLE);

  // The write counter is loaded on grant so WRITE lasts exactly WR_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_cnt     <= '0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else if (pop) begin
      wr_cnt     <= CNT_W'(WR_CYCLES - 1);
      o_mem_addr <= fifo_rdata[PAGE_LSB+PAGE_W-1:ADDR_LSB];
      o_mem_data <= fifo_rdata[DATA_LSB+DATA_W-1:DATA_LSB];
    end else if (state == WRITE && wr_cnt != '0) begin
      wr_cnt <= wr_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q     <= 1'b0;
      o_cpu_hold <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      hold_q     <= i_rom_hold;
      o_cpu_hold <= i_rom_hold | o_busy;
      if (drop)           o_overflow <= 1'b1;
      else if (hold_rise) o_overflow <= 1'b0;
    end
  end

`ifdef ROMLOAD_CKSUM_EN
  // Each byte is summed once, on the first cycle of its write pulse.
  always_ff @(posedge clk) begin
    if (!reset_n || hold_rise)
      o_cksum <= '0;
    else if (state == WRITE && wr_cnt == CNT_W'(WR_CYCLES - 1))
      o_cksum <= o_cksum + {8'h00, o_mem_data};
  end
`endif

endmodule

// File: tb/tb_romload_writer.sv
// Scoreboard bench for romload_writer: stimulus queues expected bus writes, a
// negedge monitor checks each write pulse against the queue.
module tb_romload_writer;

  localparam int DEPTH = 4;
  localparam int WRC   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_rom_hold;
  logic [5:0]  i_rom_page;
  logic [15:0] i_rom_addr;
  logic [7:0]  i_rom_data;
  logic        i_rom_wr;
  logic        i_mem_gnt;
  logic        o_mem_req;
  logic [21:0] o_mem_addr;
  logic [7:0]  o_mem_data;
  logic        o_mem_we;
  logic        o_cpu_hold;
  logic        o_busy;
  logic        o_overflow;
`ifdef ROMLOAD_CKSUM_EN
  logic [15:0] o_cksum;
`endif

  always #5 clk = ~clk;

  romload_writer #(.FIFO_DEPTH(DEPTH), .WR_CYCLES(WRC), .PTR_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rom_hold (i_rom_hold),
    .i_rom_page (i_rom_page),
    .i_rom_addr (i_rom_addr),
    .i_rom_data (i_rom_data),
    .i_rom_wr   (i_rom_wr),
    .i_mem_gnt  (i_mem_gnt),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_we   (o_mem_we),
    .o_cpu_hold (o_cpu_hold),
    .o_busy     (o_busy),
`ifdef ROMLOAD_CKSUM_EN
    .o_overflow (o_overflow),
    .o_cksum    (o_cksum)
`else
    .o_overflow (o_overflow)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected writes in order: stimulus owns wr_idx, monitor owns rd_idx.
  logic [29:0] exp_mem [256];
  int wr_idx = 0;
  int rd_idx = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe; the model accepts it only while fewer than DEPTH writes are outstanding.
  task automatic applyStimulus(input logic [5:0] page, input logic [15:0] addr, input logic [7:0] data);
    if (wr_idx - rd_idx < DEPTH) begin
      exp_mem[wr_idx % 256] = {page, addr, data};
      wr_idx++;
    end
    i_rom_page = page;
    i_rom_addr = addr;
    i_rom_data = data;
    i_rom_wr   = 1'b1;
    tick();
    i_rom_wr   = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) checkOutput("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic waitWe(input int budget, output int waited);
    waited = 0;
    @(negedge clk);
    while (!o_mem_we && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!o_mem_we) checkOutput("we_timeout", 32'(o_mem_we), 32'd1);
  endtask

  // Monitor
  int          we_run = 0;
  logic [29:0] run_val;
  logic [29:0] exp_e;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      we_run   = 0;
      prev_req = 1'b0;
    end else begin
      if (o_mem_we) begin
        if (we_run == 0) begin
          if (rd_idx == wr_idx) begin
            checkOutput("unexpected_write", 32'(o_mem_we), 32'd0);
          end else begin
            exp_e = exp_mem[rd_idx % 256];
            rd_idx++;
            checkOutput("wr_addr", 32'(o_mem_addr), 32'(exp_e[29:8]));
            checkOutput("wr_data", 32'(o_mem_data), 32'(exp_e[7:0]));
          end
          run_val = {o_mem_addr, o_mem_data};
        end else begin
          checkOutput("wr_stable", 32'({o_mem_addr, o_mem_data}), 32'(run_val));
        end
        we_run++;
      end else if (we_run != 0) begin
        checkOutput("we_len", 32'(we_run), 32'(WRC));
        we_run = 0;
      end
      if (prev_req && !prev_gnt) checkOutput("req_held", 32'(o_mem_req), 32'd1);
      prev_req = o_mem_req;
      prev_gnt = i_mem_gnt;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    bit held;
    reset_n    = 1'b0;
    i_rom_hold = 1'b0;
    i_rom_page = '0;
    i_rom_addr = '0;
    i_rom_data = '0;
    i_rom_wr   = 1'b0;
    i_mem_gnt  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_we", 32'({o_mem_req, o_mem_we}), 32'd0);
    checkOutput("rst_busy_hold_ovf", 32'({o_busy, o_cpu_hold, o_overflow}), 32'd0);
    checkOutput("rst_addr_data", 32'({o_mem_addr, o_mem_data}), 32'd0);
    tick();
    reset_n = 1'b1;

    $display("[TB] single write, latency");
    i_rom_hold = 1'b1;
    i_mem_gnt  = 1'b1;
    tick();
    applyStimulus(6'h00, 16'h0100, 8'hC3);
    waitWe(20, waited);
    checkOutput("first_we_latency", 32'(waited), 32'd2);
    @(negedge clk);
    checkOutput("we_second_cycle", 32'(o_mem_we), 32'd1);
    @(negedge clk);
    checkOutput("done_we_low", 32'(o_mem_we), 32'd0);
    checkOutput("busy_in_done", 32'(o_busy), 32'd1);
    @(negedge clk);
    checkOutput("busy_after_done", 32'(o_busy), 32'd0);

    $display("[TB] kvaz page");
    tick();
    applyStimulus(6'h05, 16'hFFFF, 8'h55);
    waitIdle(30);

    $display("[TB] grant delay");
    tick();
    i_mem_gnt = 1'b0;
    applyStimulus(6'h2A, 16'h1234, 8'hA5);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("req_wait", 32'({o_mem_req, o_mem_we}), 32'b10);
    end
    @(posedge clk);
    #1 i_mem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("we_before_gnt_edge", 32'(o_mem_we), 32'd0);
    @(negedge clk);
    checkOutput("we_after_gnt", 32'(o_mem_we), 32'd1);
    waitIdle(30);

    $display("[TB] overflow");
    tick();
    i_mem_gnt = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(6'h00, 16'(16'h0010 + i), 8'(i));
    @(negedge clk);
    checkOutput("overflow_set", 32'(o_overflow), 32'd1);
    tick();
    i_mem_gnt = 1'b1;
    waitIdle(100);
    checkOutput("ovf_all_written", 32'(rd_idx), 32'(wr_idx));
    checkOutput("overflow_sticky", 32'(o_overflow), 32'd1);
    tick();
    i_rom_hold = 1'b0;
    tick();
    i_rom_hold = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("overflow_cleared", 32'(o_overflow), 32'd0);

    $display("[TB] hold extension");
    tick();
    i_mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(6'h01, 16'(16'h2000 + i), 8'(8'h70 + i));
    i_rom_hold = 1'b0;
    i_mem_gnt  = 1'b1;
    held = 1'b1;
    waited = 0;
    @(negedge clk);
    while (o_busy && waited < 100) begin
      if (!o_cpu_hold) held = 1'b0;
      @(negedge clk);
      waited++;
    end
    checkOutput("hold_while_busy", 32'(held), 32'd1);
    checkOutput("hold_after_done", 32'(o_cpu_hold), 32'd1);
    @(negedge clk);
    checkOutput("hold_release", 32'(o_cpu_hold), 32'd0);

    $display("[TB] reset mid-write");
    tick();
    i_rom_hold = 1'b1;
    applyStimulus(6'h03, 16'h4444, 8'h11);
    applyStimulus(6'h03, 16'h4445, 8'h22);
    waitWe(20, waited);
    #1 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rstw_we_req", 32'({o_mem_we, o_mem_req}), 32'd0);
    checkOutput("rstw_busy", 32'(o_busy), 32'd0);
    checkOutput("rstw_addr_data", 32'({o_mem_addr, o_mem_data}), 32'd0);
    checkOutput("rstw_hold_ovf", 32'({o_cpu_hold, o_overflow}), 32'd0);
    wr_idx = rd_idx;
    i_rom_hold = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

`ifdef ROMLOAD_CKSUM_EN
    $display("[TB] checksum");
    i_rom_hold = 1'b1;
    i_mem_gnt  = 1'b1;
    tick();
    applyStimulus(6'h00, 16'h0000, 8'hFF);
    applyStimulus(6'h00, 16'h0001, 8'h02);
    waitIdle(50);
    checkOutput("cksum", 32'(o_cksum), 32'h0101);
`endif

    $display("[TB] random traffic");
    i_rom_hold = 1'b1;
    for (int i = 0; i < 300; i++) begin
      i_mem_gnt = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && (wr_idx - rd_idx) < DEPTH)
        applyStimulus(6'($urandom), 16'($urandom), 8'($urandom));
      else
        tick();
    end
    i_mem_gnt = 1'b1;
    waitIdle(200);
    checkOutput("rand_all_written", 32'(rd_idx), 32'(wr_idx));
    checkOutput("rand_no_overflow", 32'(o_overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
